// File: rtl/sram_req_master.sv
// Client-side master for a 64-bit byte-enable single-port SRAM: issues one access per accepted request and
// returns read data through a credit-guarded response FIFO. Define SRAM_REQ_MASTER_STATS_EN for RdCnt_DO/WrCnt_DO.
module sram_req_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrEn_SI,
  input  logic [7:0]            ReqBEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [63:0]           ReqWrData_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [63:0]           RspData_DO,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [7:0]            BEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [63:0]           WrData_DO,
  input  logic [63:0]           RdData_DI
`ifdef SRAM_REQ_MASTER_STATS_EN
  ,
  output logic [31:0]           RdCnt_DO,
  output logic [31:0]           WrCnt_DO
`endif
);

  localparam int CRED_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [CRED_W-1:0]     cred_cnt_q, cred_cnt_d;
  logic [CRED_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [63:0]           fifo_mem_q [RSP_DEPTH];
  logic [63:0]           fifo_mem_d [RSP_DEPTH];

  logic issue, rd_issue, wr_issue, push, pop, fifo_full;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Both sides use valid/ready: a transfer happens on the rising edge where valid and ready are both high;
  // the producer holds valid and payload stable until then. Every request waits for a free credit, so a
  // write can never overtake an earlier stalled read.
  assign ReqReady_SO = Rst_RBI & (cred_cnt_q < CRED_W'(RSP_DEPTH));
  assign issue       = ReqValid_SI & ReqReady_SO;
  assign rd_issue    = issue & ~ReqWrEn_SI;
  assign wr_issue    = issue & ReqWrEn_SI;

  assign CSel_SO   = issue;
  assign WrEn_SO   = wr_issue;
  assign BEn_SO    = wr_issue ? ReqBEn_SI : 8'h00;
  assign Addr_DO   = issue ? ReqAddr_DI : '0;
  assign WrData_DO = issue ? ReqWrData_DI : 64'h0;

  assign push        = rd_pipe_q[RD_LATENCY-1];
  assign fifo_full   = (fifo_cnt_q == CRED_W'(RSP_DEPTH));
  assign RspValid_SO = Rst_RBI & (fifo_cnt_q != '0);
  assign RspData_DO  = fifo_mem_q[rd_ptr_q];
  assign pop         = RspValid_SO & RspReady_SI;

  always_comb begin
    cred_cnt_d = cred_cnt_q;
    if (rd_issue && !pop)      cred_cnt_d = cred_cnt_q + CRED_W'(1);
    else if (!rd_issue && pop) cred_cnt_d = cred_cnt_q - CRED_W'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CRED_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CRED_W'(1);

    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;

    // Stage k set means read data becomes valid on RdData_DI k+1 edges after the issuing edge.
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_issue;
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];

    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = RdData_DI;
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      cred_cnt_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_pipe_q  <= '0;
    end else begin
      cred_cnt_q <= cred_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge Clk_CI) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // Credits bound in-flight reads plus occupancy, so a full FIFO never sees a push.
  assert property (@(posedge Clk_CI) disable iff (!Rst_RBI) !(push && fifo_full));

`ifdef SRAM_REQ_MASTER_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_issue ? rd_cnt_q + 32'd1 : rd_cnt_q;
    wr_cnt_d = wr_issue ? wr_cnt_q + 32'd1 : wr_cnt_q;
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign RdCnt_DO = rd_cnt_q;
  assign WrCnt_DO = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_req_master.sv
// Directed bench for sram_req_master (RD_LATENCY=2, RSP_DEPTH=4) with a behavioural SRAM, a reference
// memory and an expected-response queue checked whenever a response handshake happens.
module tb_sram_req_master;
  localparam int AW    = 10;
  localparam int RL    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wr;
  logic [7:0]    req_ben;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [63:0]   rsp_data;
  logic          csel, wren;
  logic [7:0]    ben_o;
  logic [AW-1:0] addr_o;
  logic [63:0]   wdata_o, rd_data;
`ifdef SRAM_REQ_MASTER_STATS_EN
  logic [31:0]   rd_cnt, wr_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sram_mem [1<<AW];
  logic [63:0] ref_mem  [1<<AW];
  logic [63:0] rd_stage [RL];

  // clock / reset
  always #5 clk = ~clk;

  sram_req_master #(.ADDR_WIDTH(AW), .RD_LATENCY(RL), .RSP_DEPTH(DEPTH)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .ReqValid_SI(req_valid), .ReqReady_SO(req_ready), .ReqWrEn_SI(req_wr),
    .ReqBEn_SI(req_ben), .ReqAddr_DI(req_addr), .ReqWrData_DI(req_wdata),
    .RspValid_SO(rsp_valid), .RspReady_SI(rsp_ready), .RspData_DO(rsp_data),
    .CSel_SO(csel), .WrEn_SO(wren), .BEn_SO(ben_o), .Addr_DO(addr_o),
    .WrData_DO(wdata_o), .RdData_DI(rd_data)
`ifdef SRAM_REQ_MASTER_STATS_EN
    , .RdCnt_DO(rd_cnt), .WrCnt_DO(wr_cnt)
`endif
  );

  // behavioural SRAM with RL-cycle read path
  always @(posedge clk) begin
    if (csel && wren) begin
      for (int b = 0; b < 8; b++)
        if (ben_o[b]) sram_mem[addr_o][b*8 +: 8] = wdata_o[b*8 +: 8];
    end
    if (csel && !wren) rd_stage[0] <= sram_mem[addr_o];
    for (int i = 1; i < RL; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign rd_data = rd_stage[RL-1];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", name, obs, exp);
    end
  endtask

  // driver: call at a falling edge; returns at the falling edge after acceptance or after budget cycles
  task automatic send(input logic wr, input logic [7:0] ben, input logic [AW-1:0] addr,
                      input logic [63:0] data, input int budget, output bit ok);
    req_valid = 1'b1;
    req_wr    = wr;
    req_ben   = ben;
    req_addr  = addr;
    req_wdata = data;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        check("csel_on_issue", 64'(csel), 64'd1);
        check("addr_on_issue", 64'(addr_o), 64'(addr));
        if (wr) begin
          check("ben_on_write", 64'(ben_o), 64'(ben));
          check("wren_on_write", 64'(wren), 64'd1);
          for (int b = 0; b < 8; b++)
            if (ben[b]) ref_mem[addr][b*8 +: 8] = data[b*8 +: 8];
        end else begin
          check("ben_on_read", 64'(ben_o), 64'd0);
          exp_q.push_back(ref_mem[addr]);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // scoreboard: compare every response handshake against the queue head
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
      pops++;
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base, lat;
    bit found;
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0001_0001_0001);
      ref_mem[i]  = sram_mem[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_ben = 8'h00;
    req_addr = '0; req_wdata = 64'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state, with a request held to show the SRAM side stays quiet
    req_valid = 1'b1; req_wr = 1'b1; req_ben = 8'hFF; req_addr = 10'h3A; req_wdata = 64'hDEAD;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_csel", 64'(csel), 64'd0);
    check("rst_wren", 64'(wren), 64'd0);
    check("rst_ben", 64'(ben_o), 64'd0);
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_wdata", wdata_o, 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 64'(req_ready), 64'd1);
    @(negedge clk);

    // 1: write then read back, measure read-to-response latency
    send(1'b1, 8'hFF, 10'h005, 64'h0123_4567_89AB_CDEF, 8, ok);
    check("t1_wr_accept", 64'(ok), 64'd1);
    send(1'b0, 8'h00, 10'h005, 64'h0, 8, ok);
    check("t1_rd_accept", 64'(ok), 64'd1);
    lat = 1; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      #3;
      if (rsp_valid) found = 1'b1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
    @(negedge clk);
    check("t1_rsp_seen", 64'(found), 64'd1);
    check("t1_latency", 64'(lat), 64'(RL + 1));
    repeat (4) @(negedge clk);

    // 2: partial byte-enable write merges with previous contents
    send(1'b1, 8'hFF, 10'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8, ok);
    send(1'b1, 8'h0F, 10'h010, 64'h0, 8, ok);
    send(1'b0, 8'hA5, 10'h010, 64'h0, 8, ok);
    check("t2_rd_accept", 64'(ok), 64'd1);
    repeat (6) @(negedge clk);

    // 3: back-to-back reads at full throughput
    base = pops;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 8'h00, AW'(i), 64'h0, 1, ok);
      check("t3_b2b_accept", 64'(ok), 64'd1);
    end
    check("t3_rsp_mid", 64'(pops - base), 64'(8 - (RL + 1)));
    repeat (RL + 1) @(negedge clk);
    check("t3_rsp_all", 64'(pops - base), 64'd8);
    repeat (3) @(negedge clk);

    // 4: response back-pressure exhausts credits, then drains without loss
    rsp_ready = 1'b0;
    base = pops;
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 8'h00, AW'(10'h020 + i), 64'h0, 1, ok);
      check("t4_accept", 64'(ok), 64'd1);
    end
    req_valid = 1'b1; req_wr = 1'b0; req_ben = 8'h00; req_addr = 10'h024;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_ready_blocked", 64'(req_ready), 64'd0);
      check("t4_csel_blocked", 64'(csel), 64'd0);
      check("t4_addr_blocked", 64'(addr_o), 64'd0);
      @(negedge clk);
    end
    check("t4_no_pops", 64'(pops - base), 64'd0);
    rsp_ready = 1'b1;
    send(1'b0, 8'h00, 10'h024, 64'h0, 20, ok);
    check("t4_accept5", 64'(ok), 64'd1);
    send(1'b0, 8'h00, 10'h025, 64'h0, 20, ok);
    check("t4_accept6", 64'(ok), 64'd1);
    repeat (8) @(negedge clk);
    check("t4_rsp_count", 64'(pops - base), 64'd6);

    // 5: reset with reads in flight discards them
    base = pops;
    send(1'b0, 8'h00, 10'h030, 64'h0, 1, ok);
    send(1'b0, 8'h00, 10'h031, 64'h0, 1, ok);
    rst_n = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h032;
    #1;
    check("t5_rst_ready", 64'(req_ready), 64'd0);
    check("t5_rst_csel", 64'(csel), 64'd0);
    check("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    check("t5_ready_release", 64'(req_ready), 64'd1);
    check("t5_cred_zero", 64'(dut.cred_cnt_q), 64'd0);
    repeat (8) @(negedge clk);
    check("t5_no_rsp", 64'(pops - base), 64'd0);

`ifdef SRAM_REQ_MASTER_STATS_EN
    // 6: accepted-request counters and their wrap
    for (int i = 0; i < 3; i++) send(1'b1, 8'hFF, AW'(10'h040 + i), 64'(i), 8, ok);
    for (int i = 0; i < 5; i++) send(1'b0, 8'h00, AW'(10'h040 + i), 64'h0, 8, ok);
    repeat (6) @(negedge clk);
    check("t6_wr_cnt", 64'(wr_cnt), 64'd3);
    check("t6_rd_cnt", 64'(rd_cnt), 64'd5);
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt_q;
    send(1'b0, 8'h00, 10'h050, 64'h0, 8, ok);
    #1;
    check("t6_rd_cnt_wrap", 64'(rd_cnt), 64'd0);
    repeat (6) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
